// File: rtl/cram_dram_seq.sv
// DRAM sequencer for the C64 RAM-expansion cartridge: maps the $DExx window onto
// {Block, Window, A} and runs RAS/CAS/refresh from a PHI2-synchronised DotClk phase counter.
module cram_dram_seq #(
    parameter int unsigned ROW_W      = 11,
    parameter int unsigned BLOCK_W    = 8,
    parameter int unsigned WINDOW_W   = 6,
    parameter int unsigned REF_PERIOD = 8,
    parameter bit          READBACK   = 1'b1
) (
    input  logic             DotClk,
    input  logic             RES,
    input  logic             PHI2,
    input  logic [7:0]       A,
    input  logic             nWE,
    input  logic             nIO1,
    input  logic             nIO2,
    input  logic [7:0]       Din,
    output logic [7:0]       Dout,
    output logic             Doe,
    output logic [ROW_W-1:0] RA,
    input  logic [7:0]       RDin,
    output logic             RDoe,
    output logic             nRAS,
    output logic             nCAS,
    output logic             nRWE,
    output logic             SyncLost
);

    localparam int unsigned F_W   = 2 * ROW_W;
    localparam int unsigned REF_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

    logic [3:0]          r_s;
    logic                r_phi2;
    logic                r_seen;
    logic                r_acc;
    logic                r_col;
    logic                r_sync_lost;
    logic                r_nras;
    logic                r_ncas;
    logic [REF_W-1:0]    r_ref;
    logic [BLOCK_W-1:0]  r_block;
    logic [WINDOW_W-1:0] r_window;
    logic [7:0]          r_dout;

    logic [3:0]          w_s_nxt;
    logic                w_fall;
    logic                w_ref_cyc;
    logic                w_ref_ras;
    logic                w_ref_cas;
    logic                w_acc_nxt;
    logic                w_acc_cas;
    logic                w_col_nxt;
    logic                w_reg_sel;
    logic [F_W-1:0]      w_full;
    logic [ROW_W-1:0]    w_row;
    logic [ROW_W-1:0]    w_colv;

    assign w_full    = {r_block, r_window, A};
    assign w_row     = w_full[F_W-1:ROW_W];
    assign w_colv    = w_full[ROW_W-1:0];
    assign w_reg_sel = READBACK & ~nIO2 & (A[7:1] == 7'h7F);

    // Next phase and strobe requests; strobes are decided from the next phase
    always_comb begin
        w_fall  = r_phi2 & ~PHI2 & r_seen;
        w_s_nxt = r_s;
        if (w_fall) begin
            w_s_nxt = 4'd1;
        end else if (r_s != 4'd0 && r_s != 4'd15) begin
            w_s_nxt = r_s + 4'd1;
        end
        w_ref_cyc = (r_ref == '0);
        w_ref_cas = w_ref_cyc & ((w_s_nxt == 4'd1) | (w_s_nxt == 4'd2));
        w_ref_ras = w_ref_cyc & ((w_s_nxt == 4'd2) | (w_s_nxt == 4'd3));
        w_acc_nxt = ~nIO1 & ((w_s_nxt == 4'd4) |
                             (r_acc & (w_s_nxt >= 4'd5) & (w_s_nxt <= 4'd7)));
        w_acc_cas = w_acc_nxt & (nWE ? (w_s_nxt >= 4'd5) : (w_s_nxt >= 4'd6));
        w_col_nxt = w_acc_nxt & (w_s_nxt >= 4'd5);
    end

    always_ff @(posedge DotClk) begin
        if (RES) begin
            r_s         <= 4'd0;
            r_phi2      <= 1'b0;
            r_seen      <= 1'b0;
            r_acc       <= 1'b0;
            r_col       <= 1'b0;
            r_sync_lost <= 1'b0;
            r_nras      <= 1'b1;
            r_ncas      <= 1'b1;
            r_ref       <= '0;
            r_block     <= '0;
            r_window    <= '0;
            r_dout      <= 8'd0;
        end else begin
            r_phi2      <= PHI2;
            if (!PHI2) begin
                r_seen <= 1'b1;
            end
            r_s         <= w_s_nxt;
            r_sync_lost <= (w_s_nxt == 4'd15);
            r_acc       <= w_acc_nxt;
            r_col       <= w_col_nxt;
            r_nras      <= ~(w_acc_nxt | w_ref_ras);
            r_ncas      <= ~(w_acc_cas | w_ref_cas);
            if (r_s == 4'd4) begin
                r_ref <= r_ref + REF_W'(1);
            end
            // Bus data is taken late in the PHI2 cycle, when it is guaranteed stable
            if (r_s == 4'd7) begin
                if (!nIO1 && nWE) begin
                    r_dout <= RDin;
                end else if (READBACK && !nIO2 && nWE && A == 8'hFF) begin
                    r_dout <= 8'(r_block);
                end else if (READBACK && !nIO2 && nWE && A == 8'hFE) begin
                    r_dout <= 8'(r_window);
                end
                if (!nIO2 && !nWE) begin
                    if (A == 8'hFF) begin
                        r_block <= BLOCK_W'(Din);
                    end else if (A == 8'hFE) begin
                        r_window <= WINDOW_W'(Din);
                    end
                end
            end
        end
    end

    assign Dout     = r_dout;
    assign Doe      = PHI2 & nWE & (~nIO1 | w_reg_sel);
    assign RA       = r_col ? w_colv : w_row;
    assign RDoe     = ~nIO1 & ~nWE;
    assign nRAS     = r_nras;
    assign nCAS     = r_ncas;
    assign nRWE     = ~(~nWE & PHI2 & ~nIO1);
    assign SyncLost = r_sync_lost;

endmodule

// File: tb/tb_cram_dram_seq.sv
// Directed bench for cram_dram_seq: phase-level behavioural model checked every
// DotClk, plus literal expectations taken per PHI2 cycle.
module tb_cram_dram_seq;

    localparam int unsigned ROW_W      = 11;
    localparam int unsigned REF_PERIOD = 8;

    logic        DotClk = 1'b0;
    logic        RES, PHI2, nWE, nIO1, nIO2;
    logic [7:0]  A, Din, RDin;
    logic [7:0]  Dout, d0_Dout;
    logic        Doe, d0_Doe;
    logic [10:0] RA, d0_RA;
    logic        RDoe, d0_RDoe, nRAS, d0_nRAS, nCAS, d0_nCAS, nRWE, d0_nRWE;
    logic        SyncLost, d0_SyncLost;

    always #5 DotClk = ~DotClk;

    cram_dram_seq #(.READBACK(1'b1)) u_dut (
        .DotClk(DotClk), .RES(RES), .PHI2(PHI2), .A(A), .nWE(nWE), .nIO1(nIO1),
        .nIO2(nIO2), .Din(Din), .Dout(Dout), .Doe(Doe), .RA(RA), .RDin(RDin),
        .RDoe(RDoe), .nRAS(nRAS), .nCAS(nCAS), .nRWE(nRWE), .SyncLost(SyncLost));

    cram_dram_seq #(.READBACK(1'b0)) u_dut0 (
        .DotClk(DotClk), .RES(RES), .PHI2(PHI2), .A(A), .nWE(nWE), .nIO1(nIO1),
        .nIO2(nIO2), .Din(Din), .Dout(d0_Dout), .Doe(d0_Doe), .RA(d0_RA), .RDin(RDin),
        .RDoe(d0_RDoe), .nRAS(d0_nRAS), .nCAS(d0_nCAS), .nRWE(d0_nRWE),
        .SyncLost(d0_SyncLost));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase number, refresh slot counter, registers, expected strobes
    int         m_s = 0, m_ref = 0;
    bit         m_seen = 0, m_prev = 0, m_acc = 0, m_col = 0, m_sl = 0, m_valid = 0, m_fall;
    bit         m_nras = 1, m_ncas = 1;
    logic [7:0] m_block = 0, m_dout = 0, m_dout0 = 0;
    logic [5:0] m_window = 0;

    always @(posedge DotClk) begin
        if (RES) begin
            m_s = 0; m_ref = 0; m_seen = 0; m_prev = 0; m_acc = 0; m_col = 0; m_sl = 0;
            m_nras = 1; m_ncas = 1; m_block = 0; m_window = 0; m_dout = 0; m_dout0 = 0;
            m_valid = 1;
        end else begin
            m_fall = m_prev && !PHI2 && m_seen;
            if (m_s == 7) begin
                if (!nIO1 && nWE) begin
                    m_dout = RDin; m_dout0 = RDin;
                end else if (!nIO2 && nWE && A == 8'hFF) m_dout = m_block;
                else if (!nIO2 && nWE && A == 8'hFE) m_dout = {2'b00, m_window};
                if (!nIO2 && !nWE && A == 8'hFF) m_block = Din;
                if (!nIO2 && !nWE && A == 8'hFE) m_window = Din[5:0];
            end
            if (m_s == 4) m_ref = (m_ref + 1) % REF_PERIOD;
            if (m_fall) m_s = 1;
            else if (m_s != 0 && m_s < 15) m_s = m_s + 1;
            if (!PHI2) m_seen = 1;
            m_prev = PHI2;
            if (m_s == 4) m_acc = !nIO1;
            else if (m_s >= 5 && m_s <= 7) m_acc = m_acc && !nIO1;
            else m_acc = 0;
            m_nras = !(m_acc || (m_ref == 0 && (m_s == 2 || m_s == 3)));
            m_ncas = !((m_acc && m_s >= (nWE ? 5 : 6)) || (m_ref == 0 && (m_s == 1 || m_s == 2)));
            m_col  = m_acc && m_s >= 5;
            m_sl   = (m_s == 15);
        end
    end

    logic [31:0] full, exp_ra;
    always @(negedge DotClk) begin
        if (m_valid) begin
            full   = (32'(m_block) << 14) | (32'(m_window) << 8) | 32'(A);
            exp_ra = m_col ? (full & 32'h7FF) : (full >> 11);
            check("nRAS", 32'(nRAS), 32'(m_nras));
            check("nCAS", 32'(nCAS), 32'(m_ncas));
            check("SyncLost", 32'(SyncLost), 32'(m_sl));
            check("RA", 32'(RA), exp_ra);
            check("Dout", 32'(Dout), 32'(m_dout));
            check("Doe", 32'(Doe), 32'(PHI2 && nWE && (!nIO1 || (!nIO2 && A >= 8'hFE))));
            check("nRWE", 32'(nRWE), 32'(!(!nWE && PHI2 && !nIO1)));
            check("RDoe", 32'(RDoe), 32'(!nIO1 && !nWE));
            check("rb0_Dout", 32'(d0_Dout), 32'(m_dout0));
            check("rb0_Doe", 32'(d0_Doe), 32'(PHI2 && nWE && !nIO1));
            check("rb0_nRAS", 32'(d0_nRAS), 32'(m_nras));
        end
    end

    logic        ras_s[1:16], cas_s[1:16], doe_s[1:16], doe0_s[1:16], rwe_s[1:16], rdoe_s[1:16];
    logic [10:0] ra_s[1:16];
    logic [7:0]  dout_s[1:16], dout0_s[1:16];
    int          low_cnt;

    task automatic dot(input logic phi);
        PHI2 = phi;
        @(posedge DotClk);
        @(negedge DotClk);
        #1;
    endtask

    // One PHI2 period: nl low DotClks then nh high; nIO1 released after DotClk 'cut'
    task automatic cyc(input int nl, input int nh, input logic io1, input logic io2,
                       input logic we, input logic [7:0] addr, input logic [7:0] din,
                       input logic [7:0] rdin, input int cut);
        nIO1 = io1; nIO2 = io2; nWE = we; A = addr; Din = din; RDin = rdin;
        low_cnt = 0;
        for (int k = 1; k <= nl + nh; k++) begin
            dot(k <= nl ? 1'b0 : 1'b1);
            ras_s[k] = nRAS; cas_s[k] = nCAS; ra_s[k] = RA; dout_s[k] = Dout;
            dout0_s[k] = d0_Dout; doe_s[k] = Doe; doe0_s[k] = d0_Doe;
            rwe_s[k] = nRWE; rdoe_s[k] = RDoe;
            if (!nRAS || !nCAS) low_cnt++;
            if (cut != 0 && k == cut) nIO1 = 1'b1;
        end
    endtask

    task automatic idle();
        cyc(4, 4, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 0);
    endtask

    int quiet;

    initial begin
        RES = 1'b1; PHI2 = 1'b0; nWE = 1'b1; nIO1 = 1'b1; nIO2 = 1'b1;
        A = 8'h00; Din = 8'h00; RDin = 8'h00;
        repeat (3) dot(1'b0);
        check("rst_nRAS", 32'(nRAS), 32'd1);
        check("rst_nCAS", 32'(nCAS), 32'd1);
        check("rst_SyncLost", 32'(SyncLost), 32'd0);
        check("rst_Dout", 32'(Dout), 32'd0);
        check("rst_RA", 32'(RA), 32'd0);
        RES = 1'b0;
        dot(1'b0);
        idle();
        check("unsynced_quiet", 32'(low_cnt), 32'd0);

        idle();
        check("ref_cas_s1", 32'(cas_s[1]), 32'd0);
        check("ref_cas_s2", 32'(cas_s[2]), 32'd0);
        check("ref_cas_s3", 32'(cas_s[3]), 32'd1);
        check("ref_ras_s1", 32'(ras_s[1]), 32'd1);
        check("ref_ras_s2", 32'(ras_s[2]), 32'd0);
        check("ref_ras_s3", 32'(ras_s[3]), 32'd0);
        check("ref_ras_s4", 32'(ras_s[4]), 32'd1);
        quiet = 0;
        for (int c = 0; c < 7; c++) begin
            idle();
            quiet += low_cnt;
        end
        check("no_ref_between", 32'(quiet), 32'd0);
        idle();
        check("ref_again_ras_s2", 32'(ras_s[2]), 32'd0);

        cyc(4, 4, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hA5, 8'h00, 0);
        cyc(4, 4, 1'b1, 1'b0, 1'b0, 8'hFE, 8'h2B, 8'h00, 0);
        cyc(4, 4, 1'b0, 1'b1, 1'b0, 8'h3C, 8'h77, 8'h00, 0);
        check("wr_row", 32'(ra_s[4]), 32'h52D);
        check("wr_col", 32'(ra_s[6]), 32'h33C);
        check("wr_ras_s4", 32'(ras_s[4]), 32'd0);
        check("wr_ras_s7", 32'(ras_s[7]), 32'd0);
        check("wr_ras_s8", 32'(ras_s[8]), 32'd1);
        check("wr_cas_s5", 32'(cas_s[5]), 32'd1);
        check("wr_cas_s6", 32'(cas_s[6]), 32'd0);
        check("wr_cas_s7", 32'(cas_s[7]), 32'd0);
        check("wr_cas_s8", 32'(cas_s[8]), 32'd1);
        check("wr_rwe_phi2lo", 32'(rwe_s[2]), 32'd1);
        check("wr_rwe_phi2hi", 32'(rwe_s[6]), 32'd0);
        check("wr_rdoe", 32'(rdoe_s[6]), 32'd1);

        cyc(4, 4, 1'b0, 1'b1, 1'b1, 8'h3C, 8'h00, 8'h77, 0);
        check("rd_cas_s5", 32'(cas_s[5]), 32'd0);
        check("rd_cas_s7", 32'(cas_s[7]), 32'd0);
        check("rd_dout_s7", 32'(dout_s[7]), 32'h00);
        check("rd_dout_s8", 32'(dout_s[8]), 32'h77);
        check("rd_doe_phi2hi", 32'(doe_s[6]), 32'd1);
        check("rd_doe_phi2lo", 32'(doe_s[2]), 32'd0);

        cyc(4, 4, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 0);
        check("rb_block", 32'(dout_s[8]), 32'hA5);
        check("rb_block_doe", 32'(doe_s[6]), 32'd1);
        check("rb0_doe_off", 32'(doe0_s[6]), 32'd0);
        check("rb0_dout_keep", 32'(dout0_s[8]), 32'h77);
        cyc(4, 4, 1'b1, 1'b0, 1'b1, 8'hFE, 8'h00, 8'h00, 0);
        check("rb_window", 32'(dout_s[8]), 32'h2B);

        cyc(4, 4, 1'b0, 1'b1, 1'b1, 8'h3C, 8'h00, 8'h11, 5);
        check("cut_ras_s5", 32'(ras_s[5]), 32'd0);
        check("cut_ras_s6", 32'(ras_s[6]), 32'd1);
        check("cut_cas_s6", 32'(cas_s[6]), 32'd1);
        check("cut_no_latch", 32'(dout_s[8]), 32'h2B);

        cyc(4, 2, 1'b0, 1'b1, 1'b1, 8'h3C, 8'h00, 8'h99, 0);
        check("short_ras_s6", 32'(ras_s[6]), 32'd0);
        idle();
        check("short_ras_reload", 32'(ras_s[1]), 32'd1);
        check("short_cas_reload", 32'(cas_s[1]), 32'd1);
        check("short_no_latch", 32'(dout_s[8]), 32'h2B);

        idle();
        for (int k = 1; k <= 20; k++) begin
            dot(1'b1);
            if (k == 6) check("sl_s14", 32'(SyncLost), 32'd0);
            if (k == 7) check("sl_s15", 32'(SyncLost), 32'd1);
        end
        check("sl_hold", 32'(SyncLost), 32'd1);
        check("sl_ras", 32'(nRAS), 32'd1);
        check("sl_cas", 32'(nCAS), 32'd1);
        dot(1'b0);
        check("sl_clear", 32'(SyncLost), 32'd0);
        repeat (3) dot(1'b0);
        repeat (4) dot(1'b1);

        nIO1 = 1'b0; nIO2 = 1'b1; nWE = 1'b0; A = 8'h3C; Din = 8'h55;
        repeat (4) dot(1'b0);
        repeat (2) dot(1'b1);
        check("pre_rst_ras", 32'(nRAS), 32'd0);
        RES = 1'b1;
        dot(1'b1);
        check("mid_rst_ras", 32'(nRAS), 32'd1);
        check("mid_rst_cas", 32'(nCAS), 32'd1);
        RES = 1'b0;
        dot(1'b1);
        cyc(4, 4, 1'b0, 1'b1, 1'b0, 8'h3C, 8'h66, 8'h00, 0);
        check("post_rst_quiet", 32'(low_cnt), 32'd0);
        cyc(4, 4, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 0);
        check("post_rst_block", 32'(dout_s[8]), 32'h00);
        check("post_rst_ref", 32'(ras_s[2]), 32'd0);
        cyc(4, 4, 1'b1, 1'b0, 1'b1, 8'hFE, 8'h00, 8'h00, 0);
        check("post_rst_window", 32'(dout_s[8]), 32'h00);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cram_dram_seq.md
Name: cram_dram_seq

Overview:
- Parametrised DRAM sequencer for the C64 RAM-expansion cartridge; generation after the fixed 8-bit-block/6-bit-window GeoRAM-style CPLD.
- Maps the 256-byte $DExx window (nIO1) onto {Block, Window, A[7:0]} in a multiplexed DRAM.
- Runs RAS/CAS/refresh from a DotClk-driven phase counter synchronised to PHI2.
- New over the previous generation: parametrised geometry and refresh rate, optional Block/Window register readback, and a sync-lost flag.

Parameters:
- ROW_W, 11, multiplexed DRAM address width; BLOCK_W+WINDOW_W+8 must equal 2*ROW_W.
- BLOCK_W, 8, Block register width ($DFFF).
- WINDOW_W, 6, Window register width ($DFFE).
- REF_PERIOD, 8, PHI2 cycles per CAS-before-RAS refresh (power of 2, 2..64).
- READBACK, 1, 1 = $DFFE/$DFFF readable; 0 = write-only.

Ports:
- DotClk  in  1  system clock, ~8 DotClk per PHI2.
- RES  in  1  synchronous active-high reset.
- PHI2  in  1  C64 phase-2 clock, sampled on DotClk.
- A  in  8  CPU address low byte.
- nWE  in  1  CPU write, low active.
- nIO1  in  1  $DExx select, low active.
- nIO2  in  1  $DFxx select, low active.
- Din  in  8  CPU data bus in.
- Dout  out  8  CPU data bus out.
- Doe  out  1  CPU data bus output enable.
- RA  out  ROW_W  DRAM multiplexed address.
- RDin  in  8  DRAM data in.
- RDoe  out  1  DRAM data output enable; DRAM write data is Din.
- nRAS  out  1  DRAM row strobe.
- nCAS  out  1  DRAM column strobe.
- nRWE  out  1  DRAM write enable.
- SyncLost  out  1  phase counter saturated.

Behaviour:
- Clock and reset: single clock DotClk. Reset is synchronous, active-high on RES.
- Reset values: S=0, seen=0, Ref=0, Block=0, Window=0, Dout=0, SyncLost=0, nRAS=nCAS=1, row address on RA.
- Phase counter (4 bits):
  - PHI2r <= PHI2 each cycle.
  - seen is set the first cycle PHI2=0.
  - On a falling edge (PHI2r=1, PHI2=0, seen=1), next S=1.
  - Otherwise S holds at 0, saturates at 15, else increments.
- SyncLost: registered, high while S=15; cleared when S reloads to 1.
- Strobe generation: all strobes are registered and are computed from the next S, so a strobe is valid in the same cycle as its state.
  - While S=0 or S=15, both strobes stay high.
- Refresh counter: Ref increments at S=4, mod REF_PERIOD.
- Refresh cycle (Ref=0): nCAS low for S in {1,2}; nRAS low for S in {2,3} (CAS-before-RAS).
- RAM access (nIO1=0 at S=4):
  - nRAS low for S in 4..7.
  - RA switches to column from S=5 through S=7.
  - Read: nCAS low for S in 5..7.
  - Write: nCAS low for S in 6..7.
  - All released high at S=8, or at reload to S=1, whichever comes first.
  - nIO1 deasserting mid-window releases both strobes the next cycle.
- Addressing:
  - Full address F = {Block, Window, A}, 2*ROW_W bits.
  - Row = F[2*ROW_W-1:ROW_W]; column = F[ROW_W-1:0].
  - Refresh drives the row value, which the DRAM ignores.
- Write path: nRWE = ~(~nWE & PHI2 & ~nIO1), combinational. RDoe = ~nIO1 & ~nWE.
- Read data:
  - RAM read: Dout <= RDin at S=7 when nIO1=0 and nWE=1.
  - Register read: when READBACK=1, nIO2=0 and A=$FF gives Dout <= Block; A=$FE gives Dout <= Window, zero-extended/truncated to 8 bits. Loaded at S=7.
  - Doe = PHI2 & nWE & (~nIO1 | (READBACK & ~nIO2 & A[7:1]=7'h7F)).
- Register writes, at S=7 with nIO2=0 and nWE=0:
  - A=$FF: Block <= Din (zero-extended/truncated to BLOCK_W).
  - A=$FE: Window <= Din[WINDOW_W-1:0].
  - Other $DFxx addresses: ignored.
- Simultaneous refresh and access: refresh finishes by S=3 and the access starts at S=4; both occur in the same PHI2 cycle.
- Short PHI2 cycle (reload before S=8): strobes go high the cycle S becomes 1; no read latch if S=7 was never reached.
- Reset mid-access: strobes high and registers cleared the cycle after RES is sampled. No access until after a falling PHI2 edge is seen post-reset.

Test Plan:
- Reset, then PHI2 at 8 DotClk/cycle with bus idle → S tracks 1..8. Refresh strobes appear (nCAS low S1–2, nRAS low S2–3) in the first PHI2 cycle after sync and every 8th cycle after; no other strobes.
- Write $DFFF=$A5, $DFFE=$2B, then write $DE3C=$77 → row = {A5,5} (0x52D), column = {3,3C} (0x33C). nCAS low S6–7, nRWE low only while PHI2=1, RDoe=1.
- Read $DE3C with RDin=$77 → nCAS low S5–7, Dout=$77 from S=8, Doe=1 only while PHI2=1.
- READBACK=1: read $DFFF → $A5 and $DFFE → $2B. READBACK=0: Doe stays 0 for the same reads.
- Hold PHI2 high for 20 DotClk → SyncLost=1 from S=15, no strobes. Next falling edge → S=1, SyncLost=0.
- Assert RES at S=6 of a write → nRAS=nCAS=1 next cycle, Block=Window=0. The next access waits for a new falling PHI2 edge.
